// File: rtl/seq_alu_pkg.sv
// Shared opcode, compare-flag and FSM state definitions for seq_alu.
package seq_alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'b00010;
  localparam logic [4:0] OP_ADDI   = 5'b00011;
  localparam logic [4:0] OP_SUB    = 5'b00100;
  localparam logic [4:0] OP_SUBI   = 5'b00101;
  localparam logic [4:0] OP_MUL    = 5'b00110;
  localparam logic [4:0] OP_MULI   = 5'b00111;
  localparam logic [4:0] OP_MOD    = 5'b01000;
  localparam logic [4:0] OP_MODI   = 5'b01001;
  localparam logic [4:0] OP_AND    = 5'b01010;
  localparam logic [4:0] OP_OR     = 5'b01011;
  localparam logic [4:0] OP_XOR    = 5'b01100;
  localparam logic [4:0] OP_NOT    = 5'b01101;
  localparam logic [4:0] OP_MOV    = 5'b01110;
  localparam logic [4:0] OP_MOVI   = 5'b01111;
  localparam logic [4:0] OP_MOVEQ  = 5'b10000;
  localparam logic [4:0] OP_MOVIEQ = 5'b10001;
  localparam logic [4:0] OP_MOVL   = 5'b10010;
  localparam logic [4:0] OP_MOVIL  = 5'b10011;
  localparam logic [4:0] OP_MOVG   = 5'b10100;
  localparam logic [4:0] OP_MOVIG  = 5'b10101;
  localparam logic [4:0] OP_LAD    = 5'b10110;
  localparam logic [4:0] OP_STR    = 5'b10111;
  localparam logic [4:0] OP_LSFT   = 5'b11100;
  localparam logic [4:0] OP_RSFT   = 5'b11101;

  localparam logic [1:0] FLAG_NONE = 2'b00;
  localparam logic [1:0] FLAG_EQ   = 2'b01;
  localparam logic [1:0] FLAG_LT   = 2'b10;
  localparam logic [1:0] FLAG_GT   = 2'b11;

  typedef enum logic {IDLE, ITER} state_t;

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative engine: STEP bits per cycle of shift-add multiply or restoring remainder.
// res_nxt is the value the accumulator takes at the coming step; last marks the final step.
module seq_alu_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_mod,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_nxt
);
  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = $clog2(N + 1);

  logic             mode_mod;
  logic [WIDTH:0]   acc, acc_n;
  logic [WIDTH-1:0] opa, opa_n, opb, opb_n;
  logic [CNT_W-1:0] count;

  // Multiply: opa is the left-shifting multiplicand, opb the right-shifting multiplier.
  // Remainder: opa shifts dividend bits MSB-first into acc, opb is the fixed divisor.
  always_comb begin
    acc_n = acc;
    opa_n = opa;
    opb_n = opb;
    for (int i = 0; i < STEP; i++) begin
      if (mode_mod) begin
        acc_n = {acc_n[WIDTH-1:0], opa_n[WIDTH-1]};
        opa_n = opa_n << 1;
        if (acc_n >= {1'b0, opb_n}) acc_n = acc_n - {1'b0, opb_n};
      end else begin
        if (opb_n[0]) acc_n = acc_n + {1'b0, opa_n};
        opa_n = opa_n << 1;
        opb_n = opb_n >> 1;
      end
    end
  end

  assign res_nxt = acc_n[WIDTH-1:0];
  assign last    = (count == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_mod <= 1'b0;
      acc      <= '0;
      opa      <= '0;
      opb      <= '0;
      count    <= '0;
    end else if (load) begin
      mode_mod <= is_mod;
      acc      <= '0;
      opa      <= a;
      opb      <= b;
      count    <= CNT_W'(N);
    end else if (step && count != '0) begin
      acc   <= acc_n;
      opa   <= opa_n;
      opb   <= opb_n;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU: single-cycle ops in 1 cycle, MUL/MOD iterate WIDTH/STEP cycles; owns the compare flag.
// Optional div0_err output enabled by SEQ_ALU_DIV0_ERR_EN.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       alu_control,
  input  logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_result,
  output logic [1:0]       flag
`ifdef SEQ_ALU_DIV0_ERR_EN
  , output logic           div0_err
`endif
);
  if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0 || !(STEP == 1 || STEP == 2 || STEP == 4)
      || (WIDTH % STEP) != 0) begin : g_bad_param
    $error("seq_alu: illegal WIDTH/STEP combination");
  end

  state_t             state;
  logic               sc_wr, is_iter, is_mod, shamt_ovf;
  logic [WIDTH-1:0]   sc_res, iter_res;
  logic [1:0]         flag_nxt;
  logic [SHAMT_W-1:0] shamt;
  logic               iter_last, iter_load;

  assign shamt     = alu_in2[SHAMT_W-1:0];
  assign shamt_ovf = |(alu_in2 >> SHAMT_W);
  assign iter_load = (state == IDLE) && start && is_iter;

  always_comb begin
    sc_wr    = 1'b0;
    sc_res   = '0;
    flag_nxt = flag;
    is_iter  = 1'b0;
    is_mod   = 1'b0;
    case (alu_control)
      OP_ADD, OP_ADDI: begin sc_wr = 1'b1; sc_res = alu_in1 + alu_in2; end
      OP_SUB, OP_SUBI: begin
        sc_wr    = 1'b1;
        sc_res   = alu_in1 - alu_in2;
        flag_nxt = (alu_in1 > alu_in2) ? FLAG_GT : (alu_in1 == alu_in2) ? FLAG_EQ : FLAG_LT;
      end
      OP_AND:           begin sc_wr = 1'b1; sc_res = alu_in1 & alu_in2; end
      OP_OR:            begin sc_wr = 1'b1; sc_res = alu_in1 | alu_in2; end
      OP_XOR:           begin sc_wr = 1'b1; sc_res = alu_in1 ^ alu_in2; end
      OP_NOT:           begin sc_wr = 1'b1; sc_res = ~alu_in1; end
      OP_MOV, OP_MOVI:  begin sc_wr = 1'b1; sc_res = alu_in2; end
      OP_MOVEQ, OP_MOVIEQ: begin sc_wr = (flag == FLAG_EQ); sc_res = alu_in2; end
      OP_MOVL, OP_MOVIL:   begin sc_wr = (flag == FLAG_LT); sc_res = alu_in2; end
      OP_MOVG, OP_MOVIG:   begin sc_wr = (flag == FLAG_GT); sc_res = alu_in2; end
      OP_LAD, OP_STR:   begin sc_wr = 1'b1; sc_res = alu_in1 + (alu_in2 << 2); end
      OP_LSFT:          begin sc_wr = 1'b1; sc_res = shamt_ovf ? '0 : alu_in1 << shamt; end
      OP_RSFT:          begin sc_wr = 1'b1; sc_res = shamt_ovf ? '0 : alu_in1 >> shamt; end
      OP_MUL, OP_MULI:  is_iter = 1'b1;
      OP_MOD, OP_MODI:  begin is_iter = 1'b1; is_mod = 1'b1; end
      default: ;
    endcase
  end

  seq_alu_iter #(.WIDTH(WIDTH), .STEP(STEP)) u_iter (
    .clk     (clk),
    .reset   (reset),
    .load    (iter_load),
    .step    (state == ITER),
    .is_mod  (is_mod),
    .a       (alu_in1),
    .b       (alu_in2),
    .last    (iter_last),
    .res_nxt (iter_res)
  );

`ifdef SEQ_ALU_DIV0_ERR_EN
  logic mod_b0_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      alu_result <= '0;
      flag       <= FLAG_NONE;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SEQ_ALU_DIV0_ERR_EN
      mod_b0_q   <= 1'b0;
      div0_err   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (is_iter) begin
            state <= ITER;
            busy  <= 1'b1;
`ifdef SEQ_ALU_DIV0_ERR_EN
            mod_b0_q <= is_mod && (alu_in2 == '0);
`endif
          end else begin
            done <= 1'b1;
            flag <= flag_nxt;
            if (sc_wr) alu_result <= sc_res;
`ifdef SEQ_ALU_DIV0_ERR_EN
            div0_err <= 1'b0;
`endif
          end
        end
        ITER: if (iter_last) begin
          state      <= IDLE;
          busy       <= 1'b0;
          done       <= 1'b1;
          alu_result <= iter_res;
`ifdef SEQ_ALU_DIV0_ERR_EN
          div0_err   <= mod_b0_q;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32, STEP=1 with hand-computed expectations.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  alu_control = '0;
  logic [31:0] alu_in1 = '0;
  logic [31:0] alu_in2 = '0;
  logic        busy, done;
  logic [31:0] alu_result;
  logic [1:0]  flag;
`ifdef SEQ_ALU_DIV0_ERR_EN
  logic        div0_err;
`endif

  int checks = 0;
  int errors = 0;
  int lat, bcnt;

  seq_alu #(.WIDTH(32), .STEP(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .alu_control (alu_control),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .busy        (busy),
    .done        (done),
    .alu_result  (alu_result),
    .flag        (flag)
`ifdef SEQ_ALU_DIV0_ERR_EN
    , .div0_err  (div0_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse; returns just after the capturing edge.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; alu_control = op; alu_in1 = a; alu_in2 = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Start an iterative op, fire an ADD while busy, and measure latency/busy cycles.
  task automatic run_iter(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int l, output int bc);
    do_op(op, a, b);
    l = 1; bc = 0;
    while (!done && l < 100) begin
      if (busy) bc++;
      start = (l == 3); alu_control = OP_ADD; alu_in1 = 32'd1; alu_in2 = 32'd1;
      @(negedge clk);
      l++;
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_result", alu_result, 32'h0);
    check("rst_flag", {30'd0, flag}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op(OP_ADD, 32'd5, 32'd7);
    check("add_result", alu_result, 32'd12);
    check("add_done", {31'd0, done}, 32'd1);
    check("add_flag", {30'd0, flag}, 32'd0);
    check("add_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);

    do_op(OP_SUB, 32'd3, 32'd9);
    check("sub_lt_result", alu_result, 32'hFFFF_FFFA);
    check("sub_lt_flag", {30'd0, flag}, 32'd2);
    do_op(OP_MOVL, 32'd0, 32'h55);
    check("movl_taken", alu_result, 32'h55);
    do_op(OP_MOVG, 32'd0, 32'h66);
    check("movg_held", alu_result, 32'h55);
    check("movg_done", {31'd0, done}, 32'd1);
    do_op(OP_SUBI, 32'd9, 32'd3);
    check("sub_gt_flag", {30'd0, flag}, 32'd3);
    do_op(OP_MOVIEQ, 32'd0, 32'h99);
    check("moveq_held", alu_result, 32'd6);
    do_op(OP_SUB, 32'd4, 32'd4);
    check("sub_eq_flag", {30'd0, flag}, 32'd1);
    do_op(OP_MOVEQ, 32'd0, 32'h77);
    check("moveq_taken", alu_result, 32'h77);

    run_iter(OP_MUL, 32'h0001_0000, 32'h0001_0001, lat, bcnt);
    check("mul_latency", lat, 32'd33);
    check("mul_busy_cycles", bcnt, 32'd32);
    check("mul_result", alu_result, 32'h0001_0000);
    check("mul_busy_end", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("mul_ignored_start", alu_result, 32'h0001_0000);
    check("mul_done_low", {31'd0, done}, 32'd0);
    run_iter(OP_MULI, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
    check("muli_result", alu_result, 32'h1);

    run_iter(OP_MOD, 32'd100, 32'd7, lat, bcnt);
    check("mod_latency", lat, 32'd33);
    check("mod_result", alu_result, 32'd2);
`ifdef SEQ_ALU_DIV0_ERR_EN
    check("mod_div0_clear", {31'd0, div0_err}, 32'd0);
`endif
    run_iter(OP_MODI, 32'd100, 32'd0, lat, bcnt);
    check("mod0_result", alu_result, 32'd100);
`ifdef SEQ_ALU_DIV0_ERR_EN
    check("mod0_div0_err", {31'd0, div0_err}, 32'd1);
`endif
    run_iter(OP_MOD, 32'hFFFF_FFFF, 32'd16, lat, bcnt);
    check("mod_big_result", alu_result, 32'hF);

    do_op(OP_LSFT, 32'd1, 32'd31);
    check("lsft_31", alu_result, 32'h8000_0000);
    do_op(OP_LSFT, 32'd1, 32'd32);
    check("lsft_32", alu_result, 32'h0);
    do_op(OP_RSFT, 32'h8000_0000, 32'd4);
    check("rsft_4", alu_result, 32'h0800_0000);
    do_op(OP_NOT, 32'h0F0F_0000, 32'd0);
    check("not", alu_result, 32'hF0F0_FFFF);
    do_op(OP_LAD, 32'h100, 32'd3);
    check("lad", alu_result, 32'h10C);
    check("flag_held", {30'd0, flag}, 32'd1);
    do_op(5'b00000, 32'hAAAA, 32'hBBBB);
    check("undef_result", alu_result, 32'h10C);
    check("undef_done", {31'd0, done}, 32'd1);

    do_op(OP_MUL, 32'd3, 32'd5);
    repeat (8) @(negedge clk);
    check("mid_mul_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_result", alu_result, 32'h0);
    check("async_rst_flag", {30'd0, flag}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(OP_ADD, 32'd1, 32'd1);
    check("post_rst_add", alu_result, 32'd2);
    check("post_rst_done", {31'd0, done}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
